// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared constants and helpers for the slide-switch debouncer.
//   SW_WIDTH                   : number of board slide switches
//   SW_DEBOUNCE_CYCLES_DEFAULT : 10 ms of stability at 50 MHz
//   sw_cnt_width()             : width of the per-bit stability counter
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

   localparam int SW_WIDTH                   = 10;
   localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;

   // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
   // Clamped to 1 so a degenerate parameter still yields a legal vector.
   function automatic int sw_cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
// Debounces a single switch: two-flop synchroniser, stability counter,
// debounced level flop and one-cycle change/rise/fall pulse flops.
// Ports:
//   clk_i     : system clock
//   reset_i   : asynchronous, active-high reset
//   sw_raw_i  : raw asynchronous switch level
//   sw_out_o  : debounced level
//   changed_o : one-cycle pulse when sw_out_o toggles
//   rise_o    : one-cycle pulse on a 0->1 toggle
//   fall_o    : one-cycle pulse on a 1->0 toggle
// -----------------------------------------------------------------------------
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
   parameter int   CNT_W           = sw_cnt_width(DEBOUNCE_CYCLES),
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sw_raw_i,
   output logic sw_out_o,
   output logic changed_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             chg_q, chg_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      chg_d    = 1'b0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (s2_q == stable_q) begin
         // Agreement with the current level (including a bounce back)
         // discards any partial count.
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         // This edge is the DEBOUNCE_CYCLES-th consecutive disagreement.
         stable_d = s2_q;
         cnt_d    = '0;
         chg_d    = 1'b1;
         rise_d   = s2_q;
         fall_d   = ~s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         cnt_q    <= '0;
         stable_q <= RESET_VALUE;
         chg_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         s1_q     <= sw_raw_i;
         s2_q     <= s1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         chg_q    <= chg_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign sw_out_o  = stable_q;
   assign changed_o = chg_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Conditions the slide switches ahead of the switch PIO in_port: each bit is
// synchronised and must hold a new value for DEBOUNCE_CYCLES consecutive clocks
// before sw_out follows it. Edge pulses support optional edge capture / IRQs.
// Ports:
//   clk        : system clock (PIO domain)
//   reset      : asynchronous, active-high reset
//   sw_raw     : raw switch pins (asynchronous, bouncing)
//   sw_out     : debounced level, drives PIO in_port
//   sw_changed : one-cycle pulse per bit when sw_out toggles
//   sw_rise    : one-cycle pulse per bit on 0->1
//   sw_fall    : one-cycle pulse per bit on 1->0
//   any_change : OR of sw_changed
// -----------------------------------------------------------------------------
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int               WIDTH           = SW_WIDTH,
   parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_changed,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             any_change
);

   localparam int CNT_W = sw_cnt_width(DEBOUNCE_CYCLES);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RESET_VALUE     (RESET_VALUE[i])
      ) u_bit (
         .clk_i     (clk),
         .reset_i   (reset),
         .sw_raw_i  (sw_raw[i]),
         .sw_out_o  (sw_out[i]),
         .changed_o (sw_changed[i]),
         .rise_o    (sw_rise[i]),
         .fall_o    (sw_fall[i])
      );
   end

   // OR of registered pulses only; sw_raw never reaches this output directly.
   assign any_change = |sw_changed;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

   localparam int W = 10;
   localparam int D = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_out;
   logic [W-1:0] sw_changed;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         any_change;

   int n_cmp;
   int n_err;

   sw_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .RESET_VALUE     ('0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .sw_out     (sw_out),
      .sw_changed (sw_changed),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .any_change (any_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%03h expected=0x%03h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] e_out,
                          input logic [W-1:0] e_chg, input logic [W-1:0] e_rise,
                          input logic [W-1:0] e_fall, input logic e_any);
      chk({tag, ".out"},  sw_out,     e_out);
      chk({tag, ".chg"},  sw_changed, e_chg);
      chk({tag, ".rise"}, sw_rise,    e_rise);
      chk({tag, ".fall"}, sw_fall,    e_fall);
      chk({tag, ".any"},  {{(W-1){1'b0}}, any_change}, {{(W-1){1'b0}}, e_any});
   endtask

   // Advance one clock, leaving time just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n ticks during which sw_out must stay at e_out with no pulses.
   task automatic hold_chk(input string tag, input int n, input logic [W-1:0] e_out);
      for (int k = 0; k < n; k++) begin
         tick();
         chk_all($sformatf("%s[%0d]", tag, k), e_out, '0, '0, '0, 1'b0);
      end
   endtask

   // Drive a level long enough to be fully accepted.
   task automatic settle(input logic [W-1:0] v);
      sw_raw = v;
      repeat (D + 4) tick();
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      reset  = 1'b1;
      sw_raw = '0;
      tick();
      tick();
      chk_all("rst_init", '0, '0, '0, '0, 1'b0);

      // ---- async reset with all switches high ----
      reset = 1'b0;
      settle(10'h3FF);
      chk("pre_rst.out", sw_out, 10'h3FF);
      #2 reset = 1'b1;          // mid-cycle, no clock edge involved
      #1 chk_all("rst_async", '0, '0, '0, '0, 1'b0);
      tick();
      tick();
      chk_all("rst_hold", '0, '0, '0, '0, 1'b0);
      reset = 1'b0;             // released between edges; next edge is E0
      hold_chk("rel_wait", 5, '0);
      tick();
      chk_all("rel_6th", 10'h3FF, 10'h3FF, 10'h3FF, '0, 1'b1);
      tick();
      chk_all("rel_7th", 10'h3FF, '0, '0, '0, 1'b0);

      // ---- clean rising step on bit 0 ----
      settle(10'h000);
      chk("clean0.out", sw_out, 10'h000);
      sw_raw = 10'h001;
      hold_chk("step_wait", 5, 10'h000);
      tick();
      chk_all("step_E5", 10'h001, 10'h001, 10'h001, '0, 1'b1);
      tick();
      chk_all("step_E6", 10'h001, '0, '0, '0, 1'b0);

      // ---- clean falling step on bit 0 ----
      sw_raw = 10'h000;
      hold_chk("fstep_wait", 5, 10'h001);
      tick();
      chk_all("fstep_E5", 10'h000, 10'h001, '0, 10'h001, 1'b1);
      tick();
      chk_all("fstep_E6", 10'h000, '0, '0, '0, 1'b0);

      // ---- bounce on bit 3: never D consecutive highs ----
      for (int r = 0; r < 5; r++) begin
         sw_raw = 10'h008;
         hold_chk($sformatf("bnc_hi%0d", r), 3, 10'h000);
         sw_raw = 10'h000;
         hold_chk($sformatf("bnc_lo%0d", r), 1, 10'h000);
      end
      hold_chk("bnc_drain", 3, 10'h000);
      sw_raw = 10'h008;
      hold_chk("bnc_hold", 5, 10'h000);
      tick();
      chk_all("bnc_acc", 10'h008, 10'h008, 10'h008, '0, 1'b1);
      tick();
      chk_all("bnc_after", 10'h008, '0, '0, '0, 1'b0);

      // ---- simultaneous falling bits 0x3FF -> 0x2AA ----
      settle(10'h3FF);
      chk("multi_pre.out", sw_out, 10'h3FF);
      sw_raw = 10'h2AA;
      hold_chk("multi_wait", 5, 10'h3FF);
      tick();
      chk_all("multi_E5", 10'h2AA, 10'h155, '0, 10'h155, 1'b1);
      tick();
      chk_all("multi_E6", 10'h2AA, '0, '0, '0, 1'b0);

      // ---- reset during a count on bit 9 ----
      settle(10'h000);
      chk("rmc_pre.out", sw_out, 10'h000);
      sw_raw = 10'h200;
      hold_chk("rmc_cnt", 4, 10'h000);   // E0..E3: synchroniser + count reaches 2
      #2 reset = 1'b1;
      #1 chk_all("rmc_rst", '0, '0, '0, '0, 1'b0);
      tick();
      tick();
      chk_all("rmc_hold", '0, '0, '0, '0, 1'b0);
      reset = 1'b0;
      hold_chk("rmc_wait", 5, 10'h000);
      tick();
      chk_all("rmc_6th", 10'h200, 10'h200, 10'h200, '0, 1'b1);
      tick();
      chk_all("rmc_7th", 10'h200, '0, '0, '0, 1'b0);

      // ---- independent bits: bit0 at E0, bit1 at E2 ----
      settle(10'h000);
      chk("ind_pre.out", sw_out, 10'h000);
      sw_raw = 10'h001;
      hold_chk("ind_a", 2, 10'h000);     // E0, E1
      sw_raw = 10'h003;                  // bit 1 first sampled at E2
      hold_chk("ind_b", 3, 10'h000);     // E2..E4
      tick();
      chk_all("ind_E5", 10'h001, 10'h001, 10'h001, '0, 1'b1);
      tick();
      chk_all("ind_E6", 10'h001, '0, '0, '0, 1'b0);
      tick();
      chk_all("ind_E7", 10'h003, 10'h002, 10'h002, '0, 1'b1);
      tick();
      chk_all("ind_E8", 10'h003, '0, '0, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
